// File: rtl/dice_roller.sv
// dice_roller: conditions the raw roll button, draws two dice from free-running
// mod-6 counters and hands the result to the game FSM over valid/ack.
// Optional tumble animation phase: define DICE_ROLLER_TUMBLE_EN.
module dice_roller #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned TUMBLE_CYCLES   = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       roll_n,
    input  logic       result_ack,
    output logic [2:0] die1,
    output logic [2:0] die2,
    output logic [3:0] sum,
    output logic       result_valid,
    output logic       busy
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    // Reject parameter values that would make the timers meaningless.
    if (DEBOUNCE_CYCLES < 1 || TUMBLE_CYCLES < 1) begin : g_param_check
        $error("dice_roller: DEBOUNCE_CYCLES and TUMBLE_CYCLES must be at least 1");
    end

`ifdef DICE_ROLLER_TUMBLE_EN
    localparam int unsigned TUM_W = $clog2(TUMBLE_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, TUMBLE, HOLD} state_e;
    logic [TUM_W-1:0] tcnt_q, tcnt_d;
    logic             busy_q, busy_d;
`else
    typedef enum logic {IDLE, HOLD} state_e;
`endif

    state_e             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync_q, sync_d;
    logic               deb_q, deb_d;
    logic               deb_last_q, deb_last_d;
    logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
    logic               press_q, press_d;
    logic [2:0]         c1_q, c1_d;
    logic [2:0]         c2_q, c2_d;
    logic [2:0]         die1_q, die1_d;
    logic [2:0]         die2_q, die2_d;
    logic [3:0]         sum_q, sum_d;
    logic               result_valid_q, result_valid_d;

    // Synchronizer, debouncer and falling-edge press detector.
    always_comb begin
        sync1_d    = roll_n;
        sync_d     = sync1_q;
        deb_d      = deb_q;
        deb_cnt_d  = '0;
        deb_last_d = deb_q;
        if (sync_q != deb_q) begin
            if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_d = sync_q;
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
        press_d = deb_last_q & ~deb_q;
    end

    // Free-running mod-6 counter pair used as the random source.
    always_comb begin
        c1_d = (c1_q == 3'd5) ? 3'd0 : c1_q + 3'd1;
        c2_d = c2_q;
        if (c1_q == 3'd5) begin
            c2_d = (c2_q == 3'd5) ? 3'd0 : c2_q + 3'd1;
        end
    end

    // Roll FSM: next state, dice latching and registered status outputs.
    always_comb begin
        state_d = state_q;
        die1_d  = die1_q;
        die2_d  = die2_q;
`ifdef DICE_ROLLER_TUMBLE_EN
        tcnt_d  = tcnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (press_q) begin
                    die1_d = c1_q + 3'd1;
                    die2_d = c2_q + 3'd1;
`ifdef DICE_ROLLER_TUMBLE_EN
                    tcnt_d  = '0;
                    state_d = TUMBLE;
`else
                    state_d = HOLD;
`endif
                end
            end
`ifdef DICE_ROLLER_TUMBLE_EN
            TUMBLE: begin
                die1_d = c1_q + 3'd1;
                die2_d = c2_q + 3'd1;
                if (tcnt_q == TUM_W'(TUMBLE_CYCLES - 1)) begin
                    state_d = HOLD;
                end else begin
                    tcnt_d = tcnt_q + TUM_W'(1);
                end
            end
`endif
            HOLD: begin
                if (result_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        sum_d          = {1'b0, die1_d} + {1'b0, die2_d};
        result_valid_d = (state_d == HOLD);
`ifdef DICE_ROLLER_TUMBLE_EN
        busy_d         = (state_d == TUMBLE);
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            sync1_q        <= 1'b1;
            sync_q         <= 1'b1;
            deb_q          <= 1'b1;
            deb_last_q     <= 1'b1;
            deb_cnt_q      <= '0;
            press_q        <= 1'b0;
            c1_q           <= 3'd0;
            c2_q           <= 3'd0;
            die1_q         <= 3'd0;
            die2_q         <= 3'd0;
            sum_q          <= 4'd0;
            result_valid_q <= 1'b0;
`ifdef DICE_ROLLER_TUMBLE_EN
            tcnt_q         <= '0;
            busy_q         <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync_q         <= sync_d;
            deb_q          <= deb_d;
            deb_last_q     <= deb_last_d;
            deb_cnt_q      <= deb_cnt_d;
            press_q        <= press_d;
            c1_q           <= c1_d;
            c2_q           <= c2_d;
            die1_q         <= die1_d;
            die2_q         <= die2_d;
            sum_q          <= sum_d;
            result_valid_q <= result_valid_d;
`ifdef DICE_ROLLER_TUMBLE_EN
            tcnt_q         <= tcnt_d;
            busy_q         <= busy_d;
`endif
        end
    end

    assign die1         = die1_q;
    assign die2         = die2_q;
    assign sum          = sum_q;
    assign result_valid = result_valid_q;
`ifdef DICE_ROLLER_TUMBLE_EN
    assign busy         = busy_q;
`else
    assign busy         = 1'b0;
`endif

endmodule
